// File: rtl/pc_stack_unit.sv
// pc_stack_unit: 4004-style 12-bit program counter with circular return-address stack and bus address-nibble drive.
// Ports:
//   clock, reset            system clock; synchronous active-high reset clearing all state
//   cycle[2:0]              subcycle from control (0-2 address out, 3-6 loads, 7 sync)
//   pc_control[1:0]         0 NOP, 1 PUSH, 2 POP, 3 NOP; sampled only at the cycle-2 edge
//   pc_write_enable[2:0]    per-nibble PC load strobes, honoured at cycle 3-6 edges
//   pc_next_sel[1:0]        load source: 0 data_in, 1 inst_operand, 2 reg_data, 3 data_in
//   data_in, inst_operand, reg_data [3:0]  load source nibbles
//   reg_out_enable          register file owns the bus (FIN); also inhibits the next increment
//   addr_out[3:0], addr_out_en  address nibble onto the shared bus in cycles 0-2
//   pc[11:0], stack_depth[2:0]  current PC and number of valid stack entries
//   stack_overflow, stack_underflow  sticky error flags, built only with PC_STACK_ERR_EN
module pc_stack_unit #(
  parameter int STACK_DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  cycle,
  input  logic [1:0]  pc_control,
  input  logic [2:0]  pc_write_enable,
  input  logic [1:0]  pc_next_sel,
  input  logic [3:0]  data_in,
  input  logic [3:0]  inst_operand,
  input  logic [3:0]  reg_data,
  input  logic        reg_out_enable,
  output logic [3:0]  addr_out,
  output logic        addr_out_en,
  output logic [11:0] pc,
  output logic [2:0]  stack_depth,
  output logic        stack_overflow,
  output logic        stack_underflow
);
  localparam logic [2:0] DEPTH = 3'(STACK_DEPTH);
  localparam logic [2:0] LAST = 3'(STACK_DEPTH - 1);
  // Sized to the full 3-bit pointer range; only the first STACK_DEPTH entries are ever written.
  logic [11:0] stack [8];
  logic [2:0]  sp, sp_inc, sp_dec;
  logic [11:0] pc_inc;
  logic [3:0]  nib;
  logic        inhibit_inc, push, pop, load;
  always_comb begin
    sp_inc = (sp == LAST) ? 3'd0 : sp + 3'd1;
    sp_dec = (sp == 3'd0) ? LAST : sp - 3'd1;
    pc_inc = pc + 12'd1;
    nib = (pc_next_sel == 2'd1) ? inst_operand : (pc_next_sel == 2'd2) ? reg_data : data_in;
    push = (cycle == 3'd2) && (pc_control == 2'd1);
    pop = (cycle == 3'd2) && (pc_control == 2'd2);
    load = (cycle >= 3'd3) && (cycle <= 3'd6);
    addr_out_en = !reset && (cycle <= 3'd2) && !reg_out_enable;
    addr_out = reset ? 4'd0 : (cycle == 3'd0) ? pc[3:0] : (cycle == 3'd1) ? pc[7:4] : (cycle == 3'd2) ? pc[11:8] : 4'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= 12'd0;
      sp <= 3'd0;
      stack_depth <= 3'd0;
      inhibit_inc <= 1'b0;
      for (int i = 0; i < 8; i++) stack[i] <= 12'd0;
    end else begin
      // FIN fetches its second word from the register file, so the PC must not advance past it.
      if ((cycle <= 3'd1) && reg_out_enable) inhibit_inc <= 1'b1;
      else if (cycle == 3'd7) inhibit_inc <= 1'b0;
      if (pop) begin
        pc <= stack[sp_dec];
        sp <= sp_dec;
        stack_depth <= (stack_depth == 3'd0) ? 3'd0 : stack_depth - 3'd1;
      end else if (push) begin
        stack[sp] <= pc_inc;
        sp <= sp_inc;
        pc <= pc_inc;
        stack_depth <= (stack_depth == DEPTH) ? DEPTH : stack_depth + 3'd1;
      end else if ((cycle == 3'd2) && !inhibit_inc) begin
        pc <= pc_inc;
      end else if (load) begin
        pc[3:0] <= pc_write_enable[0] ? nib : pc[3:0];
        pc[7:4] <= pc_write_enable[1] ? nib : pc[7:4];
        pc[11:8] <= pc_write_enable[2] ? nib : pc[11:8];
      end
    end
  end
`ifdef PC_STACK_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stack_overflow <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      if (push && (stack_depth == DEPTH)) stack_overflow <= 1'b1;
      if (pop && (stack_depth == 3'd0)) stack_underflow <= 1'b1;
    end
  end
`else
  assign stack_overflow = 1'b0;
  assign stack_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and randomized checks of pc_stack_unit against a behavioural model.
module tb_pc_stack_unit;
  localparam int D = 3;
`ifdef PC_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clock = 0, reset = 0;
  logic [2:0] cycle = 0, pc_write_enable = 0;
  logic [1:0] pc_control = 0, pc_next_sel = 0;
  logic [3:0] data_in = 0, inst_operand = 0, reg_data = 0;
  logic reg_out_enable = 0;
  logic [3:0] addr_out;
  logic addr_out_en, stack_overflow, stack_underflow;
  logic [11:0] pc;
  logic [2:0] stack_depth;
  int checks = 0, errors = 0;
  logic [11:0] m_pc;
  logic [11:0] m_stack [D];
  int m_sp, m_depth;
  bit m_inh, m_ovf, m_unf;

  pc_stack_unit #(.STACK_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .cycle(cycle), .pc_control(pc_control),
    .pc_write_enable(pc_write_enable), .pc_next_sel(pc_next_sel), .data_in(data_in),
    .inst_operand(inst_operand), .reg_data(reg_data), .reg_out_enable(reg_out_enable),
    .addr_out(addr_out), .addr_out_en(addr_out_en), .pc(pc), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic set_in(input logic [2:0] c, input logic [1:0] ctl = 0, input logic [2:0] we = 0,
                        input logic [1:0] sel = 0, input logic [3:0] d = 0, input logic [3:0] io = 0,
                        input logic [3:0] rg = 0, input logic roe = 0);
    @(negedge clock);
    cycle = c; pc_control = ctl; pc_write_enable = we; pc_next_sel = sel;
    data_in = d; inst_operand = io; reg_data = rg; reg_out_enable = roe;
    #1;
  endtask

  task automatic tick;
    logic [3:0] src;
    @(posedge clock);
    if (reset) begin
      m_pc = 0; m_sp = 0; m_depth = 0; m_inh = 0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < D; i++) m_stack[i] = 0;
    end else begin
      if (cycle == 2) begin
        if (pc_control == 2) begin
          m_sp = (m_sp + D - 1) % D;
          m_pc = m_stack[m_sp];
          if (m_depth == 0) m_unf = 1; else m_depth--;
        end else if (pc_control == 1) begin
          m_pc = m_pc + 12'd1;
          m_stack[m_sp] = m_pc;
          m_sp = (m_sp + 1) % D;
          if (m_depth == D) m_ovf = 1; else m_depth++;
        end else if (!m_inh) m_pc = m_pc + 12'd1;
      end
      if (cycle >= 3 && cycle <= 6) begin
        src = (pc_next_sel == 1) ? inst_operand : (pc_next_sel == 2) ? reg_data : data_in;
        for (int k = 0; k < 3; k++) if (pc_write_enable[k]) m_pc[4*k +: 4] = src;
      end
      if (cycle <= 1 && reg_out_enable) m_inh = 1;
      else if (cycle == 7) m_inh = 0;
    end
    #1;
  endtask

  // One full system cycle; optional strobe at cycle 2 and a JUN-style 3-nibble data load at cycles 3-5.
  task automatic sys(input logic [1:0] ctl, input bit do_load, input logic [11:0] v);
    for (int c = 0; c < 8; c++) begin
      set_in(3'(c), (c == 2) ? ctl : 2'd0, (do_load && c >= 3 && c <= 5) ? 3'(1 << (c - 3)) : 3'd0,
             2'd0, (c >= 3 && c <= 5) ? v[4*(c-3) +: 4] : 4'd0);
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    set_in(0);
    checks++; if (addr_out_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", addr_out_en); end
    tick; tick;
    checks++; if (pc !== 12'h000 || stack_depth !== 3'd0) begin errors++; $display("FAIL reset_state: pc %h depth %0d exp 000/0", pc, stack_depth); end
    checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {stack_overflow, stack_underflow}); end
    reset = 0;
  endtask

  task automatic test_free_run;
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 8; c++) begin
        set_in(3'(c));
        if (c <= 2) begin
          checks++;
          if (addr_out !== ((c == 0) ? 4'(s) : 4'd0) || addr_out_en !== 1'b1) begin
            errors++; $display("FAIL free_addr s%0d c%0d: got %h/%b exp %h/1", s, c, addr_out, addr_out_en, (c == 0) ? s : 0);
          end
        end
        tick;
      end
    checks++; if (pc !== 12'h003) begin errors++; $display("FAIL free_pc: got %h exp 003", pc); end
  endtask

  task automatic test_jun_jin;
    logic [3:0] exp_n [3];
    exp_n[0] = 4'hA; exp_n[1] = 4'h5; exp_n[2] = 4'h7;
    for (int c = 0; c < 8; c++) begin
      set_in(3'(c), 0, (c == 3) ? 3'b001 : (c == 4) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000,
             (c == 5) ? 2'd1 : 2'd0, (c == 3) ? 4'hA : (c == 4) ? 4'h5 : 4'h0, 4'h7);
      tick;
    end
    checks++; if (pc !== 12'h75A) begin errors++; $display("FAIL jun_pc: got %h exp 75a", pc); end
    for (int c = 0; c < 8; c++) begin
      set_in(3'(c), 0, (c == 5) ? 3'b010 : (c == 6) ? 3'b001 : 3'b000, 2'd2, 4'h0, 4'h0,
             (c == 5) ? 4'h3 : 4'hC);
      if (c <= 2) begin
        checks++;
        if (addr_out !== exp_n[c] || addr_out_en !== 1'b1) begin errors++; $display("FAIL jun_addr c%0d: got %h exp %h", c, addr_out, exp_n[c]); end
      end
      tick;
    end
    checks++; if (pc !== 12'h73C) begin errors++; $display("FAIL jin_pc: got %h exp 73c", pc); end
  endtask

  task automatic test_push_pop;
    sys(0, 1, 12'h123);
    sys(1, 1, 12'h400);
    checks++; if (stack_depth !== 3'd1 || pc !== 12'h400) begin errors++; $display("FAIL push: depth %0d pc %h exp 1/400", stack_depth, pc); end
    for (int c = 0; c < 3; c++) begin set_in(3'(c), (c == 2) ? 2'd2 : 2'd0); tick; end
    checks++; if (pc !== 12'h124 || stack_depth !== 3'd0) begin errors++; $display("FAIL pop: pc %h depth %0d exp 124/0", pc, stack_depth); end
    for (int c = 3; c < 8; c++) begin set_in(3'(c)); tick; end
  endtask

  task automatic test_stack_wrap;
    logic [11:0] exp_ret [4];
    exp_ret[0] = 12'h041; exp_ret[1] = 12'h031; exp_ret[2] = 12'h021; exp_ret[3] = 12'h041;
    sys(0, 1, 12'h010);
    sys(1, 1, 12'h020);
    sys(1, 1, 12'h030);
    sys(1, 1, 12'h040);
    sys(1, 0, 12'h000);
    checks++; if (stack_depth !== 3'd3) begin errors++; $display("FAIL wrap_depth_sat: got %0d exp 3", stack_depth); end
    for (int p = 0; p < 4; p++) begin
      sys(2, 0, 12'h000);
      checks++;
      if (pc !== exp_ret[p] || stack_depth !== 3'(p >= 2 ? 0 : 2 - p)) begin
        errors++; $display("FAIL wrap_pop%0d: pc %h depth %0d exp %h/%0d", p, pc, stack_depth, exp_ret[p], p >= 2 ? 0 : 2 - p);
      end
    end
    checks++;
    if (stack_overflow !== ERR || stack_underflow !== ERR) begin errors++; $display("FAIL wrap_flags: got %b%b exp %b%b", stack_overflow, stack_underflow, ERR, ERR); end
  endtask

  task automatic test_fin;
    sys(0, 1, 12'h2FF);
    for (int c = 0; c < 8; c++) begin
      set_in(3'(c), 0, 0, 0, 0, 0, 0, c <= 1);
      if (c <= 2) begin
        checks++;
        if (addr_out_en !== (c == 2)) begin errors++; $display("FAIL fin_en c%0d: got %b exp %b", c, addr_out_en, c == 2); end
      end
      tick;
    end
    checks++; if (pc !== 12'h2FF) begin errors++; $display("FAIL fin_hold: got %h exp 2ff", pc); end
    sys(0, 0, 12'h000);
    checks++; if (pc !== 12'h300) begin errors++; $display("FAIL fin_resume: got %h exp 300", pc); end
  endtask

  task automatic test_pc_wrap_and_reset;
    sys(0, 1, 12'hFFF);
    sys(0, 0, 12'h000);
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL pc_wrap: got %h exp 000", pc); end
    set_in(0); tick; set_in(1); tick;
    set_in(2, 1); tick;
    set_in(3, 0, 3'b001, 0, 4'hA); tick;
    reset = 1;
    set_in(4, 0, 3'b010, 0, 4'h5); tick;
    checks++; if (pc !== 12'h000 || stack_depth !== 3'd0) begin errors++; $display("FAIL mid_reset: pc %h depth %0d exp 000/0", pc, stack_depth); end
    set_in(5, 0, 3'b100, 1, 0, 4'h7); tick;
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL mid_reset_load: got %h exp 000", pc); end
    reset = 0;
    set_in(6); tick; set_in(7); tick;
  endtask

  task automatic test_random;
    logic [11:0] exp_addr;
    for (int s = 0; s < 60; s++)
      for (int c = 0; c < 8; c++) begin
        set_in(3'(c), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0,
               2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               (c <= 1) && ($urandom_range(0, 5) == 0));
        exp_addr = (c <= 2) ? m_pc >> (4 * c) : 12'd0;
        checks++;
        if (addr_out !== exp_addr[3:0] || addr_out_en !== (c <= 2 && !reg_out_enable)) begin
          errors++; $display("FAIL rand_addr s%0d c%0d: got %h/%b exp %h", s, c, addr_out, addr_out_en, exp_addr[3:0]);
        end
        tick;
        checks++;
        if (pc !== m_pc || stack_depth !== 3'(m_depth) || stack_overflow !== (ERR & m_ovf) || stack_underflow !== (ERR & m_unf)) begin
          errors++; $display("FAIL rand_state s%0d c%0d: pc %h depth %0d flags %b%b exp %h/%0d/%b%b", s, c, pc, stack_depth,
                             stack_overflow, stack_underflow, m_pc, m_depth, ERR & m_ovf, ERR & m_unf);
        end
      end
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_jun_jin;
    test_push_pop;
    test_stack_wrap;
    test_fin;
    test_pc_wrap_and_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- 4004-style program counter and 3-level return stack, directly downstream of the CPU control sequencer.
- Consumes the control block's PC strobes: pc_control, pc_write_enable, pc_next_sel and reg_out_enable, plus the cycle count.
- Owns the 12-bit PC, the circular return-address stack and the address-nibble drive onto the shared 4-bit bus during subcycles 0-2.

Parameters:
STACK_DEPTH, 3, number of return-address levels; legal range 1-7.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high; clears all state
cycle  input  3  subcycle counter from control; 7 = sync cycle
pc_control  input  2  0 NOP, 1 PUSH, 2 POP, 3 treated as NOP
pc_write_enable  input  3  bit0 loads pc[3:0], bit1 loads pc[7:4], bit2 loads pc[11:8]
pc_next_sel  input  2  0 DATA, 1 INST, 2 REG; 3 treated as DATA
data_in  input  4  ROM data nibble
inst_operand  input  4  instruction operand nibble
reg_data  input  4  register-file read nibble
reg_out_enable  input  1  control block drives the bus from the register file (FIN)
addr_out  output  4  address nibble for the bus
addr_out_en  output  1  this block drives the bus
pc  output  12  current PC
stack_depth  output  3  valid entries, 0..STACK_DEPTH
stack_overflow  output  1  see Optional Feature
stack_underflow  output  1  see Optional Feature

Behaviour:
- Reset: the following all clear to 0.
  - pc, every stack entry, stack pointer sp, stack_depth, inhibit_inc.
  - addr_out, addr_out_en, stack_overflow, stack_underflow.
- Reset applied mid-operation discards any pending push, pop or write.
- Address drive (combinational from cycle):
  - cycle 0 -> pc[3:0]; cycle 1 -> pc[7:4]; cycle 2 -> pc[11:8].
  - addr_out_en=1 in cycles 0-2 unless reg_out_enable=1.
  - All other cycles: addr_out=0, addr_out_en=0.
- inhibit_inc flag:
  - Set at the clock edge of cycle 0 or cycle 1 if reg_out_enable=1.
  - Cleared at the clock edge of cycle 7.
- Cycle-2 clock edge, in priority order:
  1. POP: pc <= stack[(sp-1) mod STACK_DEPTH]; sp decrements mod STACK_DEPTH; no increment.
  2. PUSH: stack[sp] <= pc+1 (12-bit wrap); sp increments mod STACK_DEPTH; pc <= pc+1.
  3. Otherwise: pc <= pc+1 unless inhibit_inc=1, in which case pc holds (FIN second word does not advance).
- pc_control in any cycle other than 2 is ignored.
- PC increment wraps 0xFFF -> 0x000.
- Stack is circular:
  - PUSH at full depth overwrites the oldest entry.
  - POP at empty returns whatever entry the pointer reaches.
- stack_depth:
  - PUSH: saturating increment to STACK_DEPTH.
  - POP: saturating decrement to 0.
- Nibble loads, clock edges of cycles 3-6 only:
  - Each set bit of pc_write_enable loads its nibble from the pc_next_sel source.
  - Multiple set bits load the same nibble value.
  - pc_write_enable in cycles 0-2 and 7 is ignored.
  - pc_next_sel is don't-care when pc_write_enable=0.
- Sequence timing:
  - JUN/JMS: loads at cycles 3, 4, 5 give the new PC before the next cycle 0.
  - JIN: loads at cycles 5-6 from reg_data.
- Latency: every state change is visible on outputs one clock after the qualifying edge.

Optional Feature:
- Macro PC_STACK_ERR_EN.
- Defined:
  - stack_overflow sets sticky on PUSH with stack_depth==STACK_DEPTH.
  - stack_underflow sets sticky on POP with stack_depth==0.
  - Both clear only on reset.
- Undefined: both outputs tied 0 and no flag logic is built.
- Stack wrap behaviour is identical in both builds.

Test Plan:
- Reset, then free-run 3 system cycles with no strobes -> addr_out 0,0,0 then 1,0,0 then 2,0,0 in cycles 0-2; pc=0x003.
- JUN sequence with data 0xA then 0x5 at cycles 3/4, inst_operand 0x7 at cycle 5 -> pc=0x75A; next cycles 0-2 drive A,5,7.
- pc=0x123, PUSH at cycle 2, loads to 0x400, then next instruction POP at cycle 2 -> stack_depth 1 then 0; pc=0x124 after the pop edge.
- 4 PUSHes from pc 0x010, 0x020, 0x030, 0x040, then 4 POPs -> returns 0x041, 0x031, 0x021, 0x041; stack_depth saturates at 3; with PC_STACK_ERR_EN both flags end at 1, without it both stay 0.
- reg_out_enable=1 in cycles 0-1 at pc=0x2FF -> addr_out_en=0 in cycles 0-1 and 1 in cycle 2; pc stays 0x2FF; next system cycle without FIN -> pc=0x300.
- pc=0xFFF free-running -> pc=0x000; reset asserted at cycle 4 after JUN loads data -> pc=0, stack_depth=0, cycle-5 load suppressed.
